// File: rtl/if_id_stage_if.sv
// Bundles the fetch/decode signals of if_id_stage: instruction memory, EX feedback, ID payload, debug counters.
interface if_id_stage_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        ex_redirect;
    logic [31:0] ex_target;
    logic        ex_memRead;
    logic [4:0]  ex_rd;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic        id_valid;
    logic        id_bubble;
    logic [31:0] stall_count;
    logic [31:0] flush_count;

    // Fetch stage side.
    modport slave (
        output imem_addr,
        input  imem_rdata,
        input  ex_redirect,
        input  ex_target,
        input  ex_memRead,
        input  ex_rd,
        output id_pc,
        output id_instr,
        output id_valid,
        output id_bubble,
        output stall_count,
        output flush_count
    );

    // Environment side: memory, EX stage and ID consumer.
    modport master (
        input  imem_addr,
        output imem_rdata,
        output ex_redirect,
        output ex_target,
        output ex_memRead,
        output ex_rd,
        input  id_pc,
        input  id_instr,
        input  id_valid,
        input  id_bubble,
        input  stall_count,
        input  flush_count
    );
endinterface

// File: rtl/if_id_stage.sv
// Fetch stage and IF/ID pipeline register with load-use stall, redirect flush and event counters.
module if_id_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic          clk,
    input  logic          rst,
    if_id_stage_if.slave  bus
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned REGW = 5;
    localparam int unsigned OPW  = 7;

    localparam logic [OPW-1:0] OP_LUI    = 7'b0110111;
    localparam logic [OPW-1:0] OP_AUIPC  = 7'b0010111;
    localparam logic [OPW-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OPW-1:0] OP_RTYPE  = 7'b0110011;
    localparam logic [OPW-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPW-1:0] OP_BRANCH = 7'b1100011;

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_id_pc;
    logic [XLEN-1:0] r_id_instr;
    logic            r_id_valid;
    logic [XLEN-1:0] r_stall_count;
    logic [XLEN-1:0] r_flush_count;

    logic [OPW-1:0]  w_opcode;
    logic [REGW-1:0] w_rs1;
    logic [REGW-1:0] w_rs2;
    logic            w_rs1_used;
    logic            w_rs2_used;
    logic            w_hazard;

    // Decode source registers of the ID instruction and compare against the load in EX.
    always_comb begin
        w_opcode   = r_id_instr[OPW-1:0];
        w_rs1      = r_id_instr[19:15];
        w_rs2      = r_id_instr[24:20];
        w_rs1_used = !((w_opcode == OP_LUI) || (w_opcode == OP_AUIPC) || (w_opcode == OP_JAL));
        w_rs2_used = (w_opcode == OP_RTYPE) || (w_opcode == OP_STORE) || (w_opcode == OP_BRANCH);
        w_hazard   = bus.ex_memRead && (bus.ex_rd != '0) && r_id_valid &&
                     ((w_rs1_used && (w_rs1 == bus.ex_rd)) ||
                      (w_rs2_used && (w_rs2 == bus.ex_rd)));
    end

    // A redirect flushes ID anyway, so the bubble is only needed for a real stall.
    assign bus.id_bubble = w_hazard && !bus.ex_redirect;

    // PC and IF/ID register update: reset, then redirect, then stall, then sequential fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_id_pc       <= '0;
            r_id_instr    <= NOP_INSTR;
            r_id_valid    <= 1'b0;
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else if (bus.ex_redirect) begin
            r_pc          <= bus.ex_target;
            r_id_pc       <= '0;
            r_id_instr    <= NOP_INSTR;
            r_id_valid    <= 1'b0;
            r_flush_count <= r_flush_count + XLEN'(1);
        end else if (w_hazard) begin
            r_stall_count <= r_stall_count + XLEN'(1);
        end else begin
            r_pc          <= r_pc + XLEN'(4);
            r_id_pc       <= r_pc;
            r_id_instr    <= bus.imem_rdata;
            r_id_valid    <= 1'b1;
        end
    end

    assign bus.imem_addr   = r_pc;
    assign bus.id_pc       = r_id_pc;
    assign bus.id_instr    = r_id_instr;
    assign bus.id_valid    = r_id_valid;
    assign bus.stall_count = r_stall_count;
    assign bus.flush_count = r_flush_count;
endmodule

// File: tb/tb_if_id_stage.sv
// Testbench for if_id_stage: directed vector table for the documented scenarios, then random stimulus vs a reference model.
module tb_if_id_stage;
    logic clk;
    logic rst;
    if_id_stage_if bus ();

    if_id_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: 128 words, indexed by address bits [8:2].
    logic [31:0] mem [128];
    assign bus.imem_rdata = mem[bus.imem_addr[8:2]];

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        logic        rst;
        logic        redir;
        logic [31:0] tgt;
        logic        mr;
        logic [4:0]  rd;
        logic        e_bub;
        logic [31:0] e_pc;
        logic [31:0] e_id_pc;
        logic [31:0] e_instr;
        logic        e_valid;
        logic [31:0] e_stall;
        logic [31:0] e_flush;
    } vec_t;

    vec_t vecs[$];

    // Reference model state.
    logic [31:0] m_pc, m_id_pc, m_instr, m_stall, m_flush;
    logic        m_valid;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic vec_t mk(input logic r, input logic rd_, input logic [31:0] t, input logic m,
                                input logic [4:0] d, input logic b, input logic [31:0] pc,
                                input logic [31:0] ipc, input logic [31:0] ins, input logic v,
                                input logic [31:0] s, input logic [31:0] f);
        vec_t x;
        x.rst = r; x.redir = rd_; x.tgt = t; x.mr = m; x.rd = d; x.e_bub = b;
        x.e_pc = pc; x.e_id_pc = ipc; x.e_instr = ins; x.e_valid = v; x.e_stall = s; x.e_flush = f;
        return x;
    endfunction

    // Hazard from the rule: a load in EX writes a register that the ID instruction reads.
    function automatic logic model_hazard(input logic [31:0] ins, input logic vld,
                                          input logic mr, input logic [4:0] rd);
        logic [4:0] srcs[$];
        logic [6:0] op;
        op = ins[6:0];
        if (!(mr === 1'b1 && vld === 1'b1 && rd != 5'd0)) return 1'b0;
        if (!(op inside {7'h37, 7'h17, 7'h6F})) srcs.push_back(ins[19:15]);
        if (op inside {7'h33, 7'h23, 7'h63}) srcs.push_back(ins[24:20]);
        foreach (srcs[i]) if (srcs[i] == rd) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drive(input logic r, input logic redir, input logic [31:0] tgt,
                         input logic mr, input logic [4:0] rd);
        @(negedge clk);
        rst             = r;
        bus.ex_redirect = redir;
        bus.ex_target   = tgt;
        bus.ex_memRead  = mr;
        bus.ex_rd       = rd;
        #1;
    endtask

    task automatic check_regs(input logic [31:0] pc, input logic [31:0] ipc, input logic [31:0] ins,
                              input logic v, input logic [31:0] s, input logic [31:0] f);
        chk("imem_addr",   bus.imem_addr,   pc);
        chk("id_pc",       bus.id_pc,       ipc);
        chk("id_instr",    bus.id_instr,    ins);
        chk("id_valid",    32'(bus.id_valid), 32'(v));
        chk("stall_count", bus.stall_count, s);
        chk("flush_count", bus.flush_count, f);
    endtask

    initial begin
        rst = 1'b1;
        bus.ex_redirect = 1'b0;
        bus.ex_target   = '0;
        bus.ex_memRead  = 1'b0;
        bus.ex_rd       = '0;

        foreach (mem[i]) mem[i] = 32'h0000_0013;
        mem[0]   = 32'h00A0_0093;  // addi x1,x0,10
        mem[1]   = 32'h0010_0113;  // addi x2,x0,1
        mem[2]   = 32'h0020_8033;  // add  x0,x1,x2
        mem[3]   = 32'h0000_02B7;  // lui  x5,0
        mem[4]   = 32'h0072_0193;  // addi x3,x4,7 (imm[4:0]=7)
        mem[5]   = 32'h0020_A023;  // sw   x2,0(x1)
        mem[64]  = 32'h0050_0293;  // addi x5,x0,5 at 0x100
        mem[127] = 32'h0020_8033;  // add  at 0xFFFFFFFC

        // rst redir target mr rd | bubble pc id_pc id_instr valid stall flush
        vecs.push_back(mk(1,0,32'h0,0,0, 0, 32'h0,   32'h0,   32'h0000_0013,0,0,0));
        vecs.push_back(mk(1,0,32'h0,0,0, 0, 32'h0,   32'h0,   32'h0000_0013,0,0,0));
        vecs.push_back(mk(0,0,32'h0,0,0, 0, 32'h4,   32'h0,   32'h00A0_0093,1,0,0));
        vecs.push_back(mk(0,0,32'h0,0,0, 0, 32'h8,   32'h4,   32'h0010_0113,1,0,0));
        vecs.push_back(mk(0,0,32'h0,0,0, 0, 32'hC,   32'h8,   32'h0020_8033,1,0,0));
        vecs.push_back(mk(0,0,32'h0,1,1, 1, 32'hC,   32'h8,   32'h0020_8033,1,1,0));
        vecs.push_back(mk(0,0,32'h0,0,0, 0, 32'h10,  32'hC,   32'h0000_02B7,1,1,0));
        vecs.push_back(mk(0,0,32'h0,1,0, 0, 32'h14,  32'h10,  32'h0072_0193,1,1,0));
        vecs.push_back(mk(0,0,32'h0,1,7, 0, 32'h18,  32'h14,  32'h0020_A023,1,1,0));
        vecs.push_back(mk(0,1,32'h100,1,2, 0, 32'h100, 32'h0, 32'h0000_0013,0,1,1));
        vecs.push_back(mk(0,0,32'h0,0,0, 0, 32'h104, 32'h100, 32'h0050_0293,1,1,1));
        vecs.push_back(mk(0,1,32'hFFFF_FFFC,0,0, 0, 32'hFFFF_FFFC, 32'h0, 32'h0000_0013,0,1,2));
        vecs.push_back(mk(0,0,32'h0,0,0, 0, 32'h0,   32'hFFFF_FFFC, 32'h0020_8033,1,1,2));
        vecs.push_back(mk(0,0,32'h0,1,1, 1, 32'h0,   32'hFFFF_FFFC, 32'h0020_8033,1,2,2));
        vecs.push_back(mk(0,0,32'h0,1,1, 1, 32'h0,   32'hFFFF_FFFC, 32'h0020_8033,1,3,2));
        vecs.push_back(mk(1,0,32'h0,1,1, 1, 32'h0,   32'h0,   32'h0000_0013,0,0,0));
        vecs.push_back(mk(0,0,32'h0,0,0, 0, 32'h4,   32'h0,   32'h00A0_0093,1,0,0));

        // Directed table.
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].redir, vecs[i].tgt, vecs[i].mr, vecs[i].rd);
            chk($sformatf("v%0d id_bubble", i), 32'(bus.id_bubble), 32'(vecs[i].e_bub));
            @(posedge clk); #1;
            check_regs(vecs[i].e_pc, vecs[i].e_id_pc, vecs[i].e_instr,
                       vecs[i].e_valid, vecs[i].e_stall, vecs[i].e_flush);
        end

        // Random phase: fresh program with narrow register fields to provoke hazards.
        foreach (mem[i]) begin
            logic [31:0] w;
            logic [6:0]  ops [10];
            ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h33, 7'h23, 7'h63, 7'h13, 7'h03, 7'h73};
            w = $urandom;
            w[6:0]   = ops[$urandom_range(0, 9)];
            w[19:15] = 5'($urandom_range(0, 3));
            w[24:20] = 5'($urandom_range(0, 3));
            mem[i] = w;
        end
        m_pc = '0; m_id_pc = '0; m_instr = 32'h13; m_valid = 1'b0; m_stall = '0; m_flush = '0;

        for (int c = 0; c < 400; c++) begin
            logic        r, rdr, mr, hz, exp_bub;
            logic [31:0] tgt;
            logic [4:0]  rd;
            r   = (c == 0) || ($urandom_range(0, 99) < 3);
            rdr = ($urandom_range(0, 99) < 15);
            tgt = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 127) * 4);
            mr  = (c != 0) && ($urandom_range(0, 99) < 45);
            rd  = 5'($urandom_range(0, 3));
            drive(r, rdr, tgt, mr, rd);
            hz = model_hazard(m_instr, m_valid, mr, rd);
            exp_bub = hz && !rdr;
            chk("rnd id_bubble", 32'(bus.id_bubble), 32'(exp_bub));
            if (r) begin
                m_pc = 32'h0; m_id_pc = '0; m_instr = 32'h13; m_valid = 1'b0; m_stall = '0; m_flush = '0;
            end else if (rdr) begin
                m_pc = tgt; m_id_pc = '0; m_instr = 32'h13; m_valid = 1'b0; m_flush = m_flush + 1;
            end else if (hz) begin
                m_stall = m_stall + 1;
            end else begin
                m_instr = mem[m_pc[8:2]]; m_id_pc = m_pc; m_valid = 1'b1; m_pc = m_pc + 4;
            end
            @(posedge clk); #1;
            check_regs(m_pc, m_id_pc, m_instr, m_valid, m_stall, m_flush);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
